bank_stream_mux: RTL and testbench

- Parametrised successor to the registered SRAM-bank output mux in the IDU data-fetch path.
- Streams a programmed number of beats from NUM_BANKS SRAM bank read ports to the systolic-array feeder.
- Bank selection is either fixed or auto-rotating across a programmed bank window.
- The output has a valid/ready handshake backed by a 2-entry skid buffer, so downstream stalls lose no data.

---
 rtl/bank_stream_mux.sv | 152 +++++++++++++++
 tb/tb_bank_stream_mux.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bank_stream_mux.sv
// Streams a programmed number of beats from one of NUM_BANKS SRAM read ports, in fixed or
// auto-rotating bank order, through a 2-entry skid buffer with a valid/ready handshake.
module bank_stream_mux #(
  parameter int unsigned Es        = 8,
  parameter int unsigned NUM_BANKS = 8,
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             mode,
  input  logic [SEL_W-1:0] mux_sel,
  input  logic [SEL_W-1:0] bank_last,
  input  logic [Es-1:0]    mux_in [0:NUM_BANKS-1],
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [SEL_W-1:0] cur_bank,
  output logic [Es-1:0]    out_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             mode_q, mode_d;
  logic [SEL_W-1:0] base_q, base_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [Es-1:0]    buf0_q, buf0_d;
  logic [Es-1:0]    buf1_q, buf1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             push, pop;
  logic [Es-1:0]    sel_data;

  // Bank indices beyond the populated ports read as zero.
  always_comb begin
    sel_data = '0;
    if (32'(ptr_q) < NUM_BANKS) begin
      sel_data = mux_in[ptr_q];
    end
  end

  assign in_rdy   = (state_q == StRun) && (cnt_q != 2'd2);
  assign push     = in_rdy && in_vld;
  assign pop      = (cnt_q != 2'd0) && out_rdy;
  assign out_vld  = (cnt_q != 2'd0);
  assign out_data = out_vld ? buf0_q : '0;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign cur_bank = ptr_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    base_d  = base_q;
    last_d  = last_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len != '0) begin
            rem_d   = len;
            mode_d  = mode;
            base_d  = mux_sel;
            last_d  = bank_last;
            ptr_d   = mux_sel;
            state_d = StRun;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (push) begin
          rem_d = rem_q - 1'b1;
          if (mode_q) begin
            ptr_d = ((ptr_q == last_q) || (ptr_q == SEL_W'(NUM_BANKS - 1))) ? base_q
                                                                             : ptr_q + 1'b1;
          end
          if (rem_q == CNT_W'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (cnt_q == 2'd0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Skid buffer: buf0 is the head; a push lands in the first slot free after any pop.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    cnt_d  = cnt_q;
    if (pop) begin
      buf0_d = buf1_q;
    end
    if (push) begin
      if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop)) begin
        buf0_d = sel_data;
      end else begin
        buf1_d = sel_data;
      end
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      mode_q  <= 1'b0;
      base_q  <= '0;
      last_q  <= '0;
      ptr_q   <= '0;
      buf0_q  <= '0;
      buf1_q  <= '0;
      cnt_q   <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
      last_q  <= last_d;
      ptr_q   <= ptr_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_bank_stream_mux.sv
// Scoreboard bench for bank_stream_mux with six populated banks so out-of-range selects and the
// NUM_BANKS-1 rotation wrap are both reachable.
module tb_bank_stream_mux;

  localparam int unsigned Es = 8;
  localparam int unsigned Nb = 6;
  localparam int unsigned SelW = 3;
  localparam int unsigned CntW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [CntW-1:0] len;
  logic            mode;
  logic [SelW-1:0] mux_sel;
  logic [SelW-1:0] bank_last;
  logic [Es-1:0]   mux_in [0:Nb-1];
  logic            in_vld;
  logic            in_rdy;
  logic [SelW-1:0] cur_bank;
  logic [Es-1:0]   out_data;
  logic            out_vld;
  logic            out_rdy;
  logic            busy;
  logic            done;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  sb [$];

  bank_stream_mux #(
    .Es       (Es),
    .NUM_BANKS(Nb),
    .SEL_W    (SelW),
    .CNT_W    (CntW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .mode     (mode),
    .mux_sel  (mux_sel),
    .bank_last(bank_last),
    .mux_in   (mux_in),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .cur_bank (cur_bank),
    .out_data (out_data),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] bank_val(input int b);
    return (b < int'(Nb)) ? 8'(8'h10 + b) : 8'h00;
  endfunction

  // Pushes the expected beat sequence, then pulses start for one cycle.
  task automatic xfer(input int n, input logic m, input int sel, input int last);
    int p;
    p = sel;
    for (int i = 0; i < n; i++) begin
      sb.push_back(bank_val(p));
      if (m) begin
        if (p == last || p == int'(Nb) - 1) p = sel;
        else p++;
      end
    end
    len       = CntW'(n);
    mode      = m;
    mux_sel   = SelW'(sel);
    bank_last = SelW'(last);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_busy"}, 32'(busy), 32'd0);
      tick();
      check({tag, "_pulse"}, 32'(done), 32'd0);
    end
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  // Handshake completes at the next rising edge; inputs are stable here.
  always @(negedge clk) begin
    if (rst && out_vld && out_rdy) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        check("beat", 32'(out_data), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    int dn;
    for (int b = 0; b < int'(Nb); b++) mux_in[b] = 8'(8'h10 + b);
    rst = 1'b0; start = 1'b0; len = '0; mode = 1'b0; mux_sel = '0; bank_last = '0;
    in_vld = 1'b1; out_rdy = 1'b1;
    tick();
    tick();
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_in_rdy", 32'(in_rdy), 32'd0);
    check("rst_cur_bank", 32'(cur_bank), 32'd0);
    rst = 1'b1;
    tick();

    // Fixed bank, full throughput, one-cycle latency.
    xfer(4, 1'b0, 2, 2);
    check("fix_busy", 32'(busy), 32'd1);
    check("fix_out_vld0", 32'(out_vld), 32'd0);
    check("fix_in_rdy", 32'(in_rdy), 32'd1);
    check("fix_cur_bank", 32'(cur_bank), 32'd2);
    tick();
    check("fix_out_vld1", 32'(out_vld), 32'd1);
    check("fix_out_data1", 32'(out_data), 32'h12);
    wait_done("fix_done");

    // Rotation window 1..3.
    xfer(7, 1'b1, 1, 3);
    tick(); tick(); tick();
    check("rot_wrap_bank", 32'(cur_bank), 32'd1);
    wait_done("rot_done");

    // Rotation wrap at the last populated bank.
    xfer(5, 1'b1, 4, 7);
    wait_done("rotn_done");

    // Backpressure.
    out_rdy = 1'b0;
    xfer(5, 1'b1, 0, 4);
    tick(); tick();
    check("bp_in_rdy", 32'(in_rdy), 32'd0);
    check("bp_out_vld", 32'(out_vld), 32'd1);
    check("bp_head", 32'(out_data), 32'h10);
    tick(); tick(); tick();
    check("bp_head_hold", 32'(out_data), 32'h10);
    check("bp_in_rdy_hold", 32'(in_rdy), 32'd0);
    out_rdy = 1'b1;
    wait_done("bp_done");

    // Zero-length start.
    xfer(0, 1'b0, 3, 3);
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    check("len0_out_vld", 32'(out_vld), 32'd0);
    tick();
    check("len0_done_clr", 32'(done), 32'd0);
    check("len0_out_vld2", 32'(out_vld), 32'd0);

    // Reset with two beats buffered.
    out_rdy = 1'b0;
    xfer(5, 1'b1, 0, 2);
    tick(); tick();
    check("mrst_buffered", 32'(out_vld), 32'd1);
    rst = 1'b0;
    tick();
    check("mrst_out_vld", 32'(out_vld), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_in_rdy", 32'(in_rdy), 32'd0);
    sb.delete();
    rst = 1'b1;
    out_rdy = 1'b1;
    tick();
    check("mrst_no_done", 32'(done), 32'd0);

    // Out-of-range bank reads zero; start while busy is ignored.
    xfer(2, 1'b0, 7, 7);
    len = CntW'(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    dn = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done) dn++;
    end
    check("oor_done_count", 32'(dn), 32'd1);
    check("oor_sb_empty", 32'(sb.size()), 32'd0);
    check("oor_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
